// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scanner.
// Holds the scan FSM state enum, the blank segment word and the leading-zero mask helper.
package seven_seg_pkg;

  typedef enum logic [0:0] {ST_BLANK, ST_SHOW} state_e;

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam int unsigned MAX_DIGITS = 16;

  // Bit i set when digit i should be shown: digit 0 always, others only at or
  // below the highest non-zero nibble.
  function automatic logic [MAX_DIGITS-1:0] digit_mask(input logic [4*MAX_DIGITS-1:0] val);
    logic seen;
    logic [MAX_DIGITS-1:0] mask;
    seen = 1'b0;
    mask = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (val[4*i +: 4] != 4'h0) seen = 1'b1;
      mask[i] = seen || (i == 0);
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// Hex nibble to seven-segment pattern, active-high, bit order g..a.
module hex_to_seven_segment (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    unique case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver with per-digit blanking gap and frame-aligned updates.
// Define SEVEN_SEG_LZB_EN to darken leading-zero digits.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Counter holds remaining cycles minus one; reset loads BLANK_CYCLES so the
  // first blank after reset includes the reset cycle itself.
  localparam logic [CW-1:0] DIG_LOAD = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLK_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CW-1:0] BLK_RST  = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;
  logic                    boundary;
  logic [3:0]              nibble;
  logic [6:0]              dec;
  logic [NUM_DIGITS-1:0]   mask;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    boundary   = 1'b0;

    if (load) begin
      pend_d     = value;
      pend_dp_d  = dp;
      pend_vld_d = 1'b1;
    end

    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == '0) begin
          state_d = ST_SHOW;
          cnt_d   = DIG_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == '0) begin
          boundary = (idx_q == LAST_IDX);
          idx_d    = boundary ? '0 : idx_q + 1'b1;
          if (BLANK_CYCLES == 0) begin
            state_d = ST_SHOW;
            cnt_d   = DIG_LOAD;
          end else begin
            state_d = ST_BLANK;
            cnt_d   = BLK_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    // A load on the boundary cycle is already in pend_d and lands in this frame.
    if (boundary && pend_vld_d) begin
      disp_d     = pend_d;
      disp_dp_d  = pend_dp_d;
      pend_vld_d = 1'b0;
    end
  end

  assign nibble = disp_d[{idx_d, 2'b00} +: 4];

  hex_to_seven_segment u_dec (
    .hex (nibble),
    .seg (dec)
  );

`ifdef SEVEN_SEG_LZB_EN
  logic [MAX_DIGITS-1:0] lz_mask;
  assign lz_mask = digit_mask((4*MAX_DIGITS)'(disp_d));
  assign mask    = digit_en & lz_mask[NUM_DIGITS-1:0];
`else
  assign mask    = digit_en;
`endif

  always_comb begin
    an_d  = '0;
    seg_d = SEG_OFF;
    fd_d  = boundary;
    if (state_d == ST_SHOW && mask[idx_d]) begin
      an_d[idx_d] = 1'b1;
      seg_d       = {disp_dp_d[idx_d], dec};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      idx_q      <= '0;
      cnt_q      <= BLK_RST;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      disp_dp_q  <= '0;
      seg_q      <= SEG_OFF;
      an_q       <= '0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg        = ACTIVE_LOW ? ~seg_q : seg_q;
  assign an         = ACTIVE_LOW ? ~an_q : an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: directed plus random loads against a time-slot reference model.
module tb_seven_segment_scanner;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int B     = 1;
  localparam int P     = D + B;
  localparam int FRAME = N * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = 4'hF;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  // Model: m_t counts clocks since the last reset edge (-1 while in reset).
  int          m_t = -1;
  logic [15:0] m_pend = '0;
  logic [15:0] m_disp = '0;
  logic [3:0]  m_pdp = '0;
  logic [3:0]  m_ddp = '0;
  bit          m_pvld = 1'b0;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS   (N),
    .DIGIT_CYCLES (D),
    .BLANK_CYCLES (B),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .digit_en   (digit_en),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] font(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[h];
  endfunction

  function automatic int top_digit(input logic [15:0] v);
    int hi;
    hi = 0;
    for (int j = 0; j < N; j++) if (v[4*j +: 4] != 4'h0) hi = j;
    return hi;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic       e_fd;
    int         slot;
    int         ph;
    bit         lit;
    @(posedge clk);
    e_seg = '0;
    e_an  = '0;
    e_fd  = 1'b0;
    if (!rst_n) begin
      m_t    = -1;
      m_pend = '0;
      m_disp = '0;
      m_pdp  = '0;
      m_ddp  = '0;
      m_pvld = 1'b0;
    end else begin
      m_t++;
      if (load) begin
        m_pend = value;
        m_pdp  = dp;
        m_pvld = 1'b1;
      end
      if (m_t > 0 && (m_t % FRAME) == 0) begin
        e_fd = 1'b1;
        if (m_pvld) begin
          m_disp = m_pend;
          m_ddp  = m_pdp;
          m_pvld = 1'b0;
        end
      end
      ph   = m_t % P;
      slot = (m_t / P) % N;
      if (ph >= B) begin
        lit = digit_en[slot];
`ifdef SEVEN_SEG_LZB_EN
        lit = lit && (slot <= top_digit(m_disp));
`endif
        if (lit) begin
          e_an[slot] = 1'b1;
          e_seg      = {m_ddp[slot], font(m_disp[4*slot +: 4])};
        end
      end
    end
    #1;
    check("seg", seg, ~e_seg);
    check("an", {4'h0, an}, {4'h0, ~e_an});
    check("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Advance until the next edge is a frame boundary.
  task automatic align_boundary();
    for (int k = 0; k < 2 * FRAME && ((m_t + 1) % FRAME) != 0; k++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    value = 16'h1234;
    dp    = 4'h0;
    load  = 1'b1;
    tick();
    load = 1'b0;
    run(45);

    digit_en = 4'b1011;
    run(40);
    digit_en = 4'hF;

    align_boundary();
    tick();
    value = 16'hAAAA;
    load  = 1'b1;
    tick();
    load = 1'b0;
    run(5);
    value = 16'h00F0;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    value = '0;
    run(45);

    for (int k = 0; k < 8; k++) begin
      value = 16'($urandom);
      if (k % 3 == 1) value = value & 16'h00FF;
      if (k % 3 == 2) value = value & 16'h000F;
      dp       = 4'($urandom);
      digit_en = (k % 2 == 0) ? 4'hF : 4'($urandom);
      load     = 1'b1;
      tick();
      load = 1'b0;
      run(int'($urandom_range(1, 30)));
    end
    digit_en = 4'hF;

    align_boundary();
    value = 16'hC0DE;
    dp    = 4'b0101;
    load  = 1'b1;
    tick();
    load = 1'b0;
    run(25);

    value = 16'h5678;
    dp    = 4'h0;
    load  = 1'b1;
    tick();
    load = 1'b0;
    align_boundary();
    tick();
    for (int k = 0; k < FRAME && (m_t % FRAME) != 12; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run(45);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
